// File: rtl/fm_seq_ctrl.sv
// rtl/fm_seq_ctrl.sv - a->b->d->e first-match sequencing responder
//
// Purpose:
//   Watches for a rising edge on a. It then waits for the first b at least
//   one cycle later, and then for the first d from the cycle after that b.
//   That d is answered with e in the same cycle. Later d pulses are not
//   answered, and a re-rise of a during a transaction is ignored.
//   Completed transactions are counted. An optional watchdog aborts a wait
//   that has run too long.
//
// Configuration macro:
//   FM_SEQ_TIMEOUT_EN - when defined, the WAIT_B/WAIT_D watchdog is built and
//                       timeout_err pulses on abort. When undefined, the
//                       watchdog is absent and timeout_err is tied low.
//
// Parameters:
//   TIMEOUT  - cycles allowed in each wait state before abort (>= 2)
//   CNT_W    - width of the completed-transaction counter
//
// Ports:
//   clk          in   sole clock, posedge
//   rst          in   synchronous active-high reset
//   a            in   request, rising edge significant
//   b            in   acknowledge
//   d            in   data-valid
//   e            out  response, high on the first d seen in WAIT_D
//   busy         out  high while not IDLE
//   timeout_err  out  one-cycle registered abort pulse
//   txn_count    out  completed-transaction count (wrapping)
//   state_o      out  IDLE=0, WAIT_B=1, WAIT_D=2

module fm_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             d,
    output logic             e,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] txn_count,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_B = 2'd1,
        ST_WAIT_D = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_a_q;
    logic [CNT_W-1:0]   r_txn_count;

    logic               w_a_rise;
    logic               w_b_hit;
    logic               w_d_hit;

    assign w_a_rise = a & ~r_a_q;
    assign w_b_hit  = (r_state == ST_WAIT_B) & b;
    // A d seen in WAIT_B is deliberately not a hit; only b is consumed there.
    assign w_d_hit  = (r_state == ST_WAIT_D) & d;

`ifdef FM_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0]    r_wd;
    logic               r_timeout_err;
    logic               w_wd_expire;
    logic               w_state_change;

    // A qualifying event in the final wait cycle takes priority over expiry.
    assign w_wd_expire    = (r_state != ST_IDLE) && (r_wd == WD_LAST) &&
                            !w_b_hit && !w_d_hit;
    assign w_state_change = ((r_state == ST_IDLE) & w_a_rise) | w_b_hit |
                            w_d_hit | w_wd_expire;
    assign timeout_err    = r_timeout_err;
`else
    logic               w_unused_timeout;

    assign w_unused_timeout = TIMEOUT[0];
    assign timeout_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a_q       <= 1'b0;
            r_txn_count <= '0;
`ifdef FM_SEQ_TIMEOUT_EN
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_a_q <= a;

            if (w_d_hit) begin
                r_txn_count <= r_txn_count + CNT_W'(1);
            end

`ifdef FM_SEQ_TIMEOUT_EN
            r_timeout_err <= w_wd_expire;

            // The watchdog measures time spent in the current wait state only.
            if (w_state_change || (r_state == ST_IDLE)) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + WD_W'(1);
            end
`endif

            case (r_state)
                ST_IDLE: begin
                    if (w_a_rise) begin
                        r_state <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (b) begin
                        r_state <= ST_WAIT_D;
                    end
`ifdef FM_SEQ_TIMEOUT_EN
                    else if (w_wd_expire) begin
                        r_state <= ST_IDLE;
                    end
`endif
                end
                ST_WAIT_D: begin
                    if (d) begin
                        r_state <= ST_IDLE;
                    end
`ifdef FM_SEQ_TIMEOUT_EN
                    else if (w_wd_expire) begin
                        r_state <= ST_IDLE;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // e is decoded from registered state, so it answers d with zero latency.
    assign e         = w_d_hit;
    assign busy      = (r_state != ST_IDLE);
    assign txn_count = r_txn_count;
    assign state_o   = r_state;

endmodule

// File: tb/tb_fm_seq_ctrl.sv
// tb/tb_fm_seq_ctrl.sv - directed self-checking bench for fm_seq_ctrl

module tb_fm_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       d;
    logic       e;
    logic       busy;
    logic       timeout_err;
    logic [1:0] txn_count;
    logic [1:0] state_o;

    logic       s_e;
    logic       s_busy;
    logic       s_to;
    logic [1:0] s_cnt;
    logic [1:0] s_state;

    logic [1:0] exp_cnt;
    int         n_cmp;
    int         n_err;

    fm_seq_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .d           (d),
        .e           (e),
        .busy        (busy),
        .timeout_err (timeout_err),
        .txn_count   (txn_count),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive just after posedge, sample at negedge.
    task automatic cyc(input logic ia, input logic ib, input logic id);
        a = ia;
        b = ib;
        d = id;
        @(negedge clk);
        s_e     = e;
        s_busy  = busy;
        s_to    = timeout_err;
        s_cnt   = txn_count;
        s_state = state_o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_cnt = 2'd0;
        n_cmp++; if (s_e !== 1'b0)     begin n_err++; $display("FAIL reset_e got %b want 0", s_e); end
        n_cmp++; if (s_busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy got %b want 0", s_busy); end
        n_cmp++; if (s_to !== 1'b0)    begin n_err++; $display("FAIL reset_timeout_err got %b want 0", s_to); end
        n_cmp++; if (s_cnt !== 2'd0)   begin n_err++; $display("FAIL reset_txn_count got %0d want 0", s_cnt); end
        n_cmp++; if (s_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", s_state); end
    endtask

    task automatic test_basic;
        for (int c = 0; c < 10; c++) begin
            rst = (c < 2);
            cyc((c == 2), (c == 5), (c == 8));
            if (c >= 2) begin
                n_cmp++;
                if (s_busy !== ((c >= 3) && (c <= 8))) begin
                    n_err++; $display("FAIL basic_busy c=%0d got %b want %b", c, s_busy, ((c >= 3) && (c <= 8)));
                end
                n_cmp++;
                if (s_e !== (c == 8)) begin
                    n_err++; $display("FAIL basic_e c=%0d got %b want %b", c, s_e, (c == 8));
                end
            end
        end
        rst = 1'b0;
        exp_cnt = 2'd1;
        n_cmp++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL basic_txn_count got %0d want %0d", s_cnt, exp_cnt); end
    endtask

    task automatic test_early_simul;
        cyc(1'b1, 1'b1, 1'b0);
        n_cmp++; if (s_state !== 2'd0) begin n_err++; $display("FAIL early_rise_state got %0d want 0", s_state); end
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (s_state !== 2'd1) begin n_err++; $display("FAIL early_after_rise_state got %0d want 1", s_state); end
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (s_state !== 2'd1) begin n_err++; $display("FAIL early_b_not_seen_state got %0d want 1", s_state); end
        cyc(1'b0, 1'b1, 1'b1);
        n_cmp++; if (s_e !== 1'b0) begin n_err++; $display("FAIL simul_bd_e got %b want 0", s_e); end
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (s_state !== 2'd2) begin n_err++; $display("FAIL simul_wait_d_state got %0d want 2", s_state); end
        n_cmp++; if (s_e !== 1'b0) begin n_err++; $display("FAIL simul_no_d_e got %b want 0", s_e); end
        cyc(1'b0, 1'b0, 1'b1);
        n_cmp++; if (s_e !== 1'b1) begin n_err++; $display("FAIL simul_later_d_e got %b want 1", s_e); end
        exp_cnt = exp_cnt + 2'd1;
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (s_state !== 2'd0) begin n_err++; $display("FAIL simul_end_state got %0d want 0", s_state); end
        n_cmp++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL simul_txn_count got %0d want %0d", s_cnt, exp_cnt); end
    endtask

    task automatic test_first_match;
        for (int c = 0; c < 15; c++) begin
            cyc((c == 4) || ((c >= 6) && (c <= 13)), (c == 7), (c == 10) || (c == 11) || (c == 13));
            n_cmp++;
            if (s_e !== (c == 10)) begin
                n_err++; $display("FAIL fm_e c=%0d got %b want %b", c, s_e, (c == 10));
            end
            if (c == 7) begin
                n_cmp++; if (s_state !== 2'd1) begin n_err++; $display("FAIL fm_rerise_state got %0d want 1", s_state); end
            end
            if (c == 8) begin
                n_cmp++; if (s_state !== 2'd2) begin n_err++; $display("FAIL fm_wait_d_state got %0d want 2", s_state); end
            end
        end
        exp_cnt = exp_cnt + 2'd1;
        n_cmp++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL fm_txn_count got %0d want %0d", s_cnt, exp_cnt); end
        n_cmp++; if (s_state !== 2'd0) begin n_err++; $display("FAIL fm_end_state got %0d want 0", s_state); end
    endtask

`ifdef FM_SEQ_TIMEOUT_EN
    task automatic test_watchdog;
        for (int c = 0; c < 8; c++) begin
            cyc((c == 0), 1'b0, 1'b0);
            n_cmp++;
            if (s_to !== (c == 5)) begin
                n_err++; $display("FAIL wd_timeout_err c=%0d got %b want %b", c, s_to, (c == 5));
            end
            n_cmp++;
            if (s_busy !== ((c >= 1) && (c <= 4))) begin
                n_err++; $display("FAIL wd_busy c=%0d got %b want %b", c, s_busy, ((c >= 1) && (c <= 4)));
            end
        end
        n_cmp++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL wd_abort_txn_count got %0d want %0d", s_cnt, exp_cnt); end
        for (int c = 0; c < 7; c++) begin
            cyc((c == 0), (c == 4), (c == 6));
            if (c == 5) begin
                n_cmp++; if (s_state !== 2'd2) begin n_err++; $display("FAIL wd_last_b_state got %0d want 2", s_state); end
                n_cmp++; if (s_to !== 1'b0) begin n_err++; $display("FAIL wd_last_b_timeout_err got %b want 0", s_to); end
            end
            if (c == 6) begin
                n_cmp++; if (s_e !== 1'b1) begin n_err++; $display("FAIL wd_last_b_e got %b want 1", s_e); end
            end
        end
        exp_cnt = exp_cnt + 2'd1;
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL wd_txn_count got %0d want %0d", s_cnt, exp_cnt); end
    endtask
`else
    task automatic test_watchdog;
        cyc(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (s_to !== 1'b0) begin
                n_err++; $display("FAIL nowd_timeout_err c=%0d got %b want 0", c, s_to);
            end
        end
        n_cmp++; if (s_state !== 2'd1) begin n_err++; $display("FAIL nowd_state got %0d want 1", s_state); end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        n_cmp++; if (s_e !== 1'b1) begin n_err++; $display("FAIL nowd_e got %b want 1", s_e); end
        exp_cnt = exp_cnt + 2'd1;
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL nowd_txn_count got %0d want %0d", s_cnt, exp_cnt); end
    endtask
`endif

    task automatic test_reset_in_wait_d;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        exp_cnt = exp_cnt + 2'd1;
        cyc(1'b1, 1'b0, 1'b0);
        n_cmp++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL rstd_pre_txn_count got %0d want %0d", s_cnt, exp_cnt); end
        cyc(1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        n_cmp++; if (s_e !== 1'b1) begin n_err++; $display("FAIL rstd_comb_e got %b want 1", s_e); end
        cyc(1'b0, 1'b0, 1'b0);
        exp_cnt = 2'd0;
        n_cmp++; if (s_cnt !== 2'd0)   begin n_err++; $display("FAIL rstd_txn_count got %0d want 0", s_cnt); end
        n_cmp++; if (s_state !== 2'd0) begin n_err++; $display("FAIL rstd_state got %0d want 0", s_state); end
        n_cmp++; if (s_busy !== 1'b0)  begin n_err++; $display("FAIL rstd_busy got %b want 0", s_busy); end
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 5; t++) begin
            cyc(1'b1, 1'b0, 1'b0);
            n_cmp++; if (s_state !== 2'd0) begin n_err++; $display("FAIL b2b_rise_state t=%0d got %0d want 0", t, s_state); end
            n_cmp++; if (s_cnt !== exp_cnt) begin n_err++; $display("FAIL b2b_txn_count t=%0d got %0d want %0d", t, s_cnt, exp_cnt); end
            cyc(1'b0, 1'b1, 1'b0);
            n_cmp++; if (s_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy t=%0d got %b want 1", t, s_busy); end
            cyc(1'b0, 1'b0, 1'b1);
            n_cmp++; if (s_e !== 1'b1) begin n_err++; $display("FAIL b2b_e t=%0d got %b want 1", t, s_e); end
            exp_cnt = exp_cnt + 2'd1;
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++; if (s_cnt !== 2'd1)   begin n_err++; $display("FAIL wrap_txn_count got %0d want 1", s_cnt); end
        n_cmp++; if (s_state !== 2'd0) begin n_err++; $display("FAIL wrap_state got %0d want 0", s_state); end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        exp_cnt = 2'd0;
        rst     = 1'b1;
        a       = 1'b0;
        b       = 1'b0;
        d       = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_early_simul();
        test_first_match();
        test_watchdog();
        test_reset_in_wait_d();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
